// File: rtl/priority_arbiter_16.sv
// 16-way request arbiter with fixed-priority or round-robin selection,
// a bounded hold time per grant and a one-cycle release gap between grants.
module priority_arbiter_16 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic        gnt_valid,
  output logic [3:0]  gnt_idx,
  output logic        none,
  output logic        timeout
);

  // Hold counter only needs to reach HOLD_MAX; keep at least one bit when disabled.
  localparam int unsigned CNT_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic [3:0]         idx_q, idx_d;
  logic [3:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;

  logic [3:0]         winner;
  logic               hold_hit;
  logic               release_now;

  // Mode 0: highest asserted index wins. Mode 1: first asserted index at or
  // above ptr, wrapping 15 -> 0.
  function automatic logic [3:0] pick_winner(input logic [15:0] r,
                                             input logic        m,
                                             input logic [3:0]  p);
    logic [3:0] w;
    logic [3:0] cand;
    w = '0;
    if (m) begin
      // Walk offsets from farthest to nearest so the nearest match is kept.
      for (int i = 15; i >= 0; i--) begin
        cand = p + 4'(i);
        if (r[cand]) w = cand;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (r[i]) w = 4'(i);
      end
    end
    return w;
  endfunction

  // Winner selection and release conditions for the current grant.
  always_comb begin
    winner      = pick_winner(req, mode, ptr_q);
    hold_hit    = (HOLD_MAX != 0) && (cnt_q == CNT_W'(HOLD_MAX));
    release_now = done || !req[idx_q] || hold_hit;
  end

  // Next-state and next-output logic for the IDLE/GRANT/RELEASE sequence.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // (an unassigned path in always_comb would infer a latch).
    state_d   = state_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req != '0) begin
          state_d = S_GRANT;
          gnt_d   = 16'd1 << winner;
          valid_d = 1'b1;
          idx_d   = winner;
          ptr_d   = winner + 4'd1;
          cnt_d   = CNT_W'(1);
        end else begin
          gnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      S_GRANT: begin
        if (release_now) begin
          state_d   = S_RELEASE;
          gnt_d     = '0;
          valid_d   = 1'b0;
          cnt_d     = '0;
          // Only a pure hold-limit expiry counts as a forced release.
          timeout_d = hold_hit && !done && req[idx_q];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset that overrides every other input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_idx   = idx_q;
  assign timeout   = timeout_q;
  assign none      = (req == '0);

endmodule

// File: tb/tb_priority_arbiter_16.sv
// Bench for priority_arbiter_16: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a behavioural model.
module tb_priority_arbiter_16;

  localparam int HM = 4;

  logic        clk = 1'b0;
  logic        rst, mode, done;
  logic [15:0] req;
  logic [15:0] gnt;
  logic        gnt_valid, none, timeout;
  logic [3:0]  gnt_idx;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  priority_arbiter_16 #(.HOLD_MAX(HM)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx),
    .none     (none),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = waiting, 1 = holding a grant, 2 = gap cycle.
  int m_phase = 0;
  int m_idx   = 0;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_valid = 0;
  bit m_to    = 0;
  bit m_lim;

  function automatic int model_winner(input logic [15:0] r, input logic m, input int p);
    if (!m) begin
      for (int i = 15; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 0; k < 16; k++) if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return 0;
  endfunction

  // Model advance on each rising edge from the inputs held across it.
  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_valid = 0; m_to = 0;
    end else begin
      case (m_phase)
        0: begin
          m_to = 0;
          if (req != 16'h0) begin
            m_idx   = model_winner(req, mode, m_ptr);
            m_ptr   = (m_idx + 1) % 16;
            m_valid = 1;
            m_hold  = 1;
            m_phase = 1;
          end
        end
        1: begin
          m_lim = (HM != 0) && (m_hold == HM);
          if (done || !req[m_idx] || m_lim) begin
            m_to    = m_lim && !done && req[m_idx];
            m_valid = 0;
            m_hold  = 0;
            m_phase = 2;
          end else begin
            m_hold++;
          end
        end
        default: begin
          m_to    = 0;
          m_phase = 0;
        end
      endcase
    end
  end

  // Single compare process: every falling edge, outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("gnt",       gnt,       m_valid ? (32'd1 << m_idx) : 32'd0);
      check("gnt_valid", gnt_valid, m_valid);
      check("gnt_idx",   gnt_idx,   m_idx);
      check("timeout",   timeout,   m_to);
      check("none",      none,      req == 16'h0);
    end
  end

  // Advance one clock; inputs change shortly after the edge, outputs settled.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; done = 1'b0; req = 16'h0; mode = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  int valid_cycles;

  initial begin
    rst = 1'b1; mode = 1'b0; req = 16'h0; done = 1'b0;
    tick();
    cmp_en = 1'b1;
    check("rst_gnt",   gnt, 16'h0);
    check("rst_valid", gnt_valid, 1'b0);
    check("rst_idx",   gnt_idx, 4'd0);
    check("rst_to",    timeout, 1'b0);

    // Fixed priority, done on third grant cycle, regrant three cycles later.
    do_reset();
    req = 16'h8421;
    tick(); check("fp_c1", gnt, 16'h8000); check("fp_idx", gnt_idx, 4'd15);
    tick(); check("fp_c2", gnt, 16'h8000);
    tick(); check("fp_c3", gnt, 16'h8000); done = 1'b1;
    tick(); check("fp_rel", gnt_valid, 1'b0); done = 1'b0;
    tick(); check("fp_idle", gnt, 16'h0);
    tick(); check("fp_regrant", gnt, 16'h8000);

    // Round-robin wrap between requesters 0 and 15.
    do_reset();
    mode = 1'b1; req = 16'h8001; done = 1'b1;
    tick(); check("rr_g0", gnt_idx, 4'd0);
    tick(); tick(); tick(); check("rr_g1", gnt_idx, 4'd15);
    tick(); tick(); tick(); check("rr_g2", gnt_idx, 4'd0);
    tick(); tick(); tick(); check("rr_g3", gnt_idx, 4'd15);
    done = 1'b0;

    // Hold-limit expiry with HOLD_MAX = 4.
    do_reset();
    req = 16'h0010;
    valid_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (gnt_valid) valid_cycles++;
    end
    check("to_hold_len", valid_cycles, 4);
    tick(); check("to_pulse", timeout, 1'b1); check("to_gnt_off", gnt_valid, 1'b0);
    tick(); check("to_pulse_end", timeout, 1'b0);
    tick(); check("to_regrant", gnt, 16'h0010);

    // Granted requester drops while another is waiting.
    do_reset();
    req = 16'h0084;
    tick(); check("drop_idx7", gnt_idx, 4'd7);
    req = 16'h0004;
    tick(); check("drop_rel", gnt_valid, 1'b0); check("drop_to", timeout, 1'b0);
    tick();
    tick(); check("drop_regrant", gnt, 16'h0004);

    // Reset in the middle of a grant; pointer must restart at 0.
    do_reset();
    req = 16'h0200;
    tick(); check("mr_idx9", gnt_idx, 4'd9);
    rst = 1'b1;
    tick(); check("mr_gnt", gnt, 16'h0); check("mr_valid", gnt_valid, 1'b0);
    check("mr_idx", gnt_idx, 4'd0); check("mr_to", timeout, 1'b0);
    rst = 1'b0; mode = 1'b1; req = 16'h0A00;
    tick(); check("mr_ptr0", gnt_idx, 4'd9);

    // No requests for ten cycles, done toggling, stays idle.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      done = i[0];
      tick();
      check("idle_none", none, 1'b1);
      check("idle_valid", gnt_valid, 1'b0);
    end
    done = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: req = 16'h0;
          1: req = 16'd1 << $urandom_range(0, 15);
          2: req = 16'($urandom);
          default: req = 16'($urandom) & 16'($urandom) & 16'($urandom);
        endcase
      end
      mode = 1'($urandom_range(0, 1));
      done = ($urandom_range(0, 4) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    tick();
    cmp_en = 1'b0;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/priority_arbiter_16.md
PRIORITY_ARBITER_16 -- requirements
Module: priority_arbiter_16

Interface
REQ-001 Parameter HOLD_MAX, default 8: maximum cycles a grant is held before forced release; 0 disables the limit.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port mode  input  1  arbitration policy: 0 = fixed priority, 1 = round-robin.
REQ-005 Port req  input  16  request lines, one per requester, level-sensitive.
REQ-006 Port done  input  1  granted requester finished; meaningful only while gnt_valid = 1.
REQ-007 Port gnt  output  16  one-hot grant vector, registered.
REQ-008 Port gnt_valid  output  1  high while a grant is held, registered.
REQ-009 Port gnt_idx  output  4  index of the current or last granted requester, registered.
REQ-010 Port none  output  1  combinational: high when req == 0.
REQ-011 Port timeout  output  1  one-cycle pulse when a grant is force-released by HOLD_MAX, registered.

Function
REQ-012 The block SHALL implement FSM states IDLE, GRANT, RELEASE.
REQ-013 In IDLE with req != 0, the block SHALL select a winner and enter GRANT next edge; gnt[winner], gnt_valid, gnt_idx SHALL be valid one cycle after req is sampled.
REQ-014 In IDLE with req == 0, the block SHALL stay in IDLE with gnt = 0, gnt_valid = 0.
REQ-015 mode = 0: winner SHALL be the highest-index asserted req bit (bit 15 highest priority).
REQ-016 mode = 1: winner SHALL be the first asserted bit scanning upward from pointer ptr, wrapping 15 -> 0.
REQ-017 ptr (4-bit) SHALL load winner+1 modulo 16 on every grant in either mode; winner 15 SHALL set ptr = 0.
REQ-018 mode SHALL be sampled only in IDLE; changes during GRANT/RELEASE SHALL not affect the current grant.
REQ-019 gnt SHALL be exactly one-hot when gnt_valid = 1 and all-zero otherwise.
REQ-020 In GRANT, a hold counter SHALL start at 1 on the first GRANT cycle and increment each cycle.
REQ-021 GRANT SHALL exit to RELEASE on the edge after any of: done = 1, req[gnt_idx] = 0, or (HOLD_MAX != 0 and counter == HOLD_MAX).
REQ-022 If done and the HOLD_MAX limit coincide, the release SHALL count as normal; timeout SHALL stay 0.
REQ-023 timeout SHALL pulse high for exactly the RELEASE cycle following a HOLD_MAX-only exit.
REQ-024 RELEASE SHALL last exactly one cycle with gnt = 0, gnt_valid = 0, then go to IDLE; req SHALL not be evaluated in RELEASE.
REQ-025 Minimum spacing: release condition at cycle t -> gnt low at t+1 -> IDLE at t+2 -> next grant at t+3.
REQ-026 gnt_idx SHALL retain its last value outside GRANT.
REQ-027 Requests asserted or dropped by non-granted requesters during GRANT SHALL not alter the grant.

Reset
REQ-028 With rst = 1 at a rising edge the block SHALL enter IDLE and set gnt = 0, gnt_valid = 0, gnt_idx = 0, ptr = 0, counter = 0, timeout = 0, regardless of current state.
REQ-029 rst SHALL override done, req and the HOLD_MAX limit in the same cycle; a grant active during reset SHALL be dropped with no RELEASE cycle and no timeout pulse.
REQ-030 The first grant after reset release SHALL follow REQ-013 from IDLE.

Verification
REQ-031 Fixed priority: mode=0, req=16'h8421 held, done at 3rd GRANT cycle -> gnt=16'h8000, gnt_idx=15 for 3 cycles; RELEASE one cycle; then gnt=16'h8000 again.
REQ-032 Round-robin wrap: mode=1, req=16'h8001 held, done each grant cycle -> grants alternate idx 0, 15, 0, 15; ptr wraps 15 -> 0.
REQ-033 Timeout: HOLD_MAX=4, mode=0, req=16'h0010 held, done=0 -> gnt_valid high exactly 4 cycles, timeout=1 in the following cycle only, regrant of idx 4 two cycles later.
REQ-034 Request drop: grant idx 7, then req[7] deasserts while req[2]=1 -> RELEASE next cycle, gnt=16'h0004 at t+3, timeout=0.
REQ-035 Reset mid-grant: assert rst during GRANT of idx 9 -> next cycle all outputs at reset values, ptr=0, no timeout pulse.
REQ-036 Idle/none: req=0 for 10 cycles -> none=1, gnt_valid=0, state stays IDLE; done pulses ignored.
